// File: rtl/int2flt_seq.sv
// Sequential signed int16 -> IEEE-754 binary16 converter over a single data_mem port.
// Optional macro I2F_STATUS_EN adds a status byte write (zero/inexact/negative) at OUT_ADDR+2.
module int2flt_seq #(
    parameter logic [7:0] IN_ADDR  = 8'd0,
    parameter logic [7:0] OUT_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       done,
    output logic [7:0] dm_addr,
    output logic       dm_wr_en,
    output logic [7:0] dm_din,
    input  logic [7:0] dm_dout
);

    typedef enum logic [3:0] {
        IDLE, RD_LO, RD_HI, NORM, ROUND, WR_LO, WR_HI, WR_ST, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [7:0]  lo_q, lo_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [4:0]  exp_q, exp_d;
    logic [15:0] result_q, result_d;
`ifdef I2F_STATUS_EN
    logic        inexact_q, inexact_d;
`endif

    logic        trigger;
    logic [15:0] raw;

    // Round-to-nearest-even of a normalized magnitude (mag[15] is the hidden bit).
    function automatic logic [15:0] round_pack(input logic s, input logic [4:0] e,
                                               input logic [15:0] m);
        logic [9:0]  mant;
        logic [10:0] mant_inc;
        logic [4:0]  ex;
        mant     = m[14:5];
        ex       = e;
        mant_inc = {1'b0, mant} + 11'd1;
        if (m[4] & ((|m[3:0]) | mant[0])) begin
            if (mant_inc[10]) begin
                mant = 10'd0;
                ex   = e + 5'd1;
            end else begin
                mant = mant_inc[9:0];
            end
        end
        return {s, ex, mant};
    endfunction

    assign trigger = start_q & ~start;
    assign raw     = {dm_dout, lo_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            lo_q      <= 8'd0;
            sign_q    <= 1'b0;
            mag_q     <= 16'd0;
            exp_q     <= 5'd0;
            result_q  <= 16'd0;
`ifdef I2F_STATUS_EN
            inexact_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            lo_q      <= lo_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            result_q  <= result_d;
`ifdef I2F_STATUS_EN
            inexact_q <= inexact_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        result_d  = result_q;
`ifdef I2F_STATUS_EN
        inexact_d = inexact_q;
`endif
        done      = 1'b0;
        dm_addr   = 8'd0;
        dm_wr_en  = 1'b0;
        dm_din    = 8'd0;

        case (state_q)
            IDLE: if (trigger) state_d = RD_LO;
            RD_LO: begin
                dm_addr = IN_ADDR;
                lo_d    = dm_dout;
                state_d = RD_HI;
            end
            RD_HI: begin
                dm_addr   = IN_ADDR + 8'd1;
                sign_d    = raw[15];
                mag_d     = raw[15] ? (~raw + 16'd1) : raw;
                exp_d     = 5'd30;
`ifdef I2F_STATUS_EN
                inexact_d = 1'b0;
`endif
                state_d   = NORM;
            end
            NORM: begin
                if (mag_q == 16'd0) begin
                    result_d = 16'h0000;
                    state_d  = WR_LO;
                end else if (!mag_q[15]) begin
                    mag_d = {mag_q[14:0], 1'b0};
                    exp_d = exp_q - 5'd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d  = round_pack(sign_q, exp_q, mag_q);
`ifdef I2F_STATUS_EN
                inexact_d = mag_q[4] | (|mag_q[3:0]);
`endif
                state_d   = WR_LO;
            end
            WR_LO: begin
                dm_addr  = OUT_ADDR;
                dm_din   = result_q[7:0];
                dm_wr_en = 1'b1;
                state_d  = WR_HI;
            end
            WR_HI: begin
                dm_addr  = OUT_ADDR + 8'd1;
                dm_din   = result_q[15:8];
                dm_wr_en = 1'b1;
`ifdef I2F_STATUS_EN
                state_d  = WR_ST;
`else
                state_d  = DONE;
`endif
            end
`ifdef I2F_STATUS_EN
            WR_ST: begin
                dm_addr  = OUT_ADDR + 8'd2;
                dm_din   = {5'd0, result_q[15], inexact_q, (result_q == 16'd0)};
                dm_wr_en = 1'b1;
                state_d  = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int2flt_seq.sv
// Directed bench for int2flt_seq with a behavioural byte-wide data memory.
module tb_int2flt_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_din;
    logic [7:0] dm_dout;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'd0;
    logic [7:0] tb_data = 8'd0;

    int passed = 0;
    int total  = 0;

`ifdef I2F_STATUS_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    int2flt_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .done    (done),
        .dm_addr (dm_addr),
        .dm_wr_en(dm_wr_en),
        .dm_din  (dm_din),
        .dm_dout (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_wr_en) mem[dm_addr] <= dm_din;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    typedef struct {
        logic [15:0] in;
        logic [15:0] res;
        logic [7:0]  st;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic check_le(input string name, input int got, input int lim);
        total++;
        if (got >= 0 && got <= lim) passed++;
        else $display("FAIL %s: got %0d expected <= %0d", name, got, lim);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic load(input logic [15:0] x);
        poke(8'd0, x[7:0]);
        poke(8'd1, x[15:8]);
        poke(8'd2, 8'hA5);
        poke(8'd3, 8'hA5);
        poke(8'd4, 8'hA5);
    endtask

    // Falling edge of start is seen at the second posedge after this begins.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // lat = busy cycles between trigger and DONE; -1 if done never seen.
    task automatic convert(input logic [15:0] x, output logic [15:0] res,
                           output logic [7:0] st, output int lat, output int width);
        int cyc;
        load(x);
        pulse_start();
        lat   = -1;
        width = 0;
        res   = 16'hxxxx;
        st    = 8'hxx;
        cyc   = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - 1;
                res = {mem[3], mem[2]};
                st  = mem[4];
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (lat >= 0) begin
            width = 1;
            @(negedge clk);
            if (done) width++;
        end
    endtask

    initial begin
        vec_t        vecs[12];
        logic [15:0] res;
        logic [7:0]  st;
        int          lat, width, dcnt;

        vecs[0]  = '{16'h0001, 16'h3C00, 8'h00};
        vecs[1]  = '{16'h0000, 16'h0000, 8'h01};
        vecs[2]  = '{16'h7FFF, 16'h7800, 8'h02};
        vecs[3]  = '{16'h8000, 16'hF800, 8'h04};
        vecs[4]  = '{16'hFFFF, 16'hBC00, 8'h04};
        vecs[5]  = '{16'h0801, 16'h6800, 8'h02};
        vecs[6]  = '{16'h0803, 16'h6802, 8'h02};
        vecs[7]  = '{16'h0400, 16'h6400, 8'h00};
        vecs[8]  = '{16'hFC00, 16'hE400, 8'h04};
        vecs[9]  = '{16'h00FF, 16'h5BF8, 8'h00};
        vecs[10] = '{16'h7FF0, 16'h77FF, 8'h00};
        vecs[11] = '{16'hFFFE, 16'hC000, 8'h04};

        @(negedge clk);
        @(negedge clk);
        check("reset_done", int'(done), 0);
        check("reset_wr_en", int'(dm_wr_en), 0);
        check("reset_addr", int'(dm_addr), 0);
        check("reset_din", int'(dm_din), 0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            convert(vecs[i].in, res, st, lat, width);
            check($sformatf("result_%04h", vecs[i].in), int'(res), int'(vecs[i].res));
            check_le($sformatf("latency_%04h", vecs[i].in), lat, 21 + EXTRA);
            check($sformatf("done_width_%04h", vecs[i].in), width, 1);
`ifdef I2F_STATUS_EN
            check($sformatf("status_%04h", vecs[i].in), int'(st), int'(vecs[i].st));
`else
            check($sformatf("no_status_%04h", vecs[i].in), int'(st), 8'hA5);
`endif
            if (vecs[i].in == 16'h0000) check("latency_min", lat, 5 + EXTRA);
            if (vecs[i].in == 16'h0001) check("latency_max", lat, 21 + EXTRA);
            @(negedge clk);
        end

        // Reset asserted while normalizing aborts with no write and no done.
        load(16'h0001);
        pulse_start();
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_done", int'(done), 0);
        check("abort_wr_en", int'(dm_wr_en), 0);
        check("abort_addr", int'(dm_addr), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_mem_untouched", int'({mem[3], mem[2]}), 16'hA5A5);
        convert(16'h0803, res, st, lat, width);
        check("after_abort_result", int'(res), 16'h6802);

        // Falling edges of start while busy must not retrigger.
        @(negedge clk);
        load(16'h0001);
        pulse_start();
        dcnt = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 3 || i == 6) start = 1'b1;
            if (i == 4 || i == 7) start = 1'b0;
            if (done) dcnt++;
            @(negedge clk);
        end
        check("busy_one_done", dcnt, 1);
        check("busy_result", int'({mem[3], mem[2]}), 16'h3C00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
